// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types, standard mode tables and sync-window helpers.
// Used by vga_timing_gen and its sub-module.
package vga_timing_pkg;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_active;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
    } timing_t;

    localparam timing_t VGA_640x480 = '{
        h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96,  h_bp: 16'd48,
        v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,   v_bp: 16'd33
    };

    localparam timing_t VGA_800x600 = '{
        h_active: 16'd800, h_fp: 16'd40, h_sync: 16'd128, h_bp: 16'd88,
        v_active: 16'd600, v_fp: 16'd1,  v_sync: 16'd4,   v_bp: 16'd23
    };

    function automatic int unsigned total_of(input int unsigned active, input int unsigned fp,
                                             input int unsigned sw, input int unsigned bp);
        return active + fp + sw + bp;
    endfunction

    // Returns the asserted level inside [start, start+width-1], the idle level elsewhere.
    function automatic logic sync_level(input int unsigned pos, input int unsigned start,
                                        input int unsigned width, input logic pol);
        return ((pos >= start) && (pos < start + width)) ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_clk_en.sv
// Pixel-rate strobe generator: one-Clk ce every CLK_DIV enabled cycles.
// The count freezes while en is low; ce is forced low during Reset.
module vga_clk_en #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic en,
    output logic ce
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] r_div;
    logic          w_at_last;

    assign w_at_last = (r_div == DIV_LAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_div <= '0;
        end else if (en) begin
            r_div <= w_at_last ? '0 : r_div + 1'b1;
        end
    end

    // With CLK_DIV=1 the counter sits at 0 and ce collapses to en.
    assign ce = en & ~Reset & w_at_last;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel strobe, DrawX/DrawY, registered syncs, blanking.
// Define VGA_TIMING_FRAME_COUNT_EN to add the 16-bit frame_count output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = int'(VGA_640x480.h_active),
    parameter int unsigned H_FP     = int'(VGA_640x480.h_fp),
    parameter int unsigned H_SYNC   = int'(VGA_640x480.h_sync),
    parameter int unsigned H_BP     = int'(VGA_640x480.h_bp),
    parameter int unsigned V_ACTIVE = int'(VGA_640x480.v_active),
    parameter int unsigned V_FP     = int'(VGA_640x480.v_fp),
    parameter int unsigned V_SYNC   = int'(VGA_640x480.v_sync),
    parameter int unsigned V_BP     = int'(VGA_640x480.v_bp),
    parameter int unsigned CLK_DIV  = 2,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = 11
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          en,
    output logic          pixel_ce,
    output logic          hs,
    output logic          vs,
    output logic          blank,
    output logic          sync,
    output logic [CW-1:0] DrawX,
    output logic [CW-1:0] DrawY,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
    ,
    output logic [15:0]   frame_count
`endif
);

    localparam int unsigned H_TOTAL  = total_of(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL  = total_of(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam longint unsigned CNT_RANGE = 64'd1 << CW;

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
        $error("vga_timing_gen: timing parameters must be non-zero");
    end
    if (64'(H_TOTAL) > CNT_RANGE || 64'(V_TOTAL) > CNT_RANGE) begin : g_bad_cw
        $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
    end

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    logic          w_ce;
    logic          w_x_last;
    logic          w_y_last;
    logic [CW-1:0] w_x_next;
    logic [CW-1:0] w_y_next;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_hs;
    logic          r_vs;

    vga_clk_en #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_en (
        .Clk   (Clk),
        .Reset (Reset),
        .en    (en),
        .ce    (w_ce)
    );

    assign w_x_last = (r_x == H_LAST);
    assign w_y_last = (r_y == V_LAST);

    always_comb begin
        w_x_next = w_x_last ? '0 : r_x + 1'b1;
        w_y_next = r_y;
        if (w_x_last) begin
            w_y_next = w_y_last ? '0 : r_y + 1'b1;
        end
    end

    // Syncs are computed from the next counter value so the registered
    // output lines up with the DrawX/DrawY it belongs to.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_x  <= '0;
            r_y  <= '0;
            r_hs <= ~HS_POL;
            r_vs <= ~VS_POL;
        end else if (w_ce) begin
            r_x  <= w_x_next;
            r_y  <= w_y_next;
            r_hs <= sync_level(32'(w_x_next), HS_START, H_SYNC, HS_POL);
            r_vs <= sync_level(32'(w_y_next), VS_START, V_SYNC, VS_POL);
        end
    end

    assign pixel_ce    = w_ce;
    assign DrawX       = r_x;
    assign DrawY       = r_y;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign sync        = 1'b0;
    assign blank       = (32'(r_x) < H_ACTIVE) && (32'(r_y) < V_ACTIVE);
    assign line_start  = w_ce & (r_x == '0);
    assign frame_start = line_start & (r_y == '0);

`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] r_frame_count;
    logic        r_first_seen;

    // The first frame after reset is frame 0; later frame_starts advance the count.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_frame_count <= '0;
            r_first_seen  <= 1'b0;
        end else if (frame_start) begin
            r_first_seen <= 1'b1;
            if (r_first_seen) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign frame_count = r_frame_count;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default mode line checks, a reduced mode
// under random en with mid-frame reset, and a CLK_DIV=1 inverted-polarity mode.
module tb_vga_timing_gen;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic sync_exp(input int pos, input int start, input int width,
                                      input logic pol);
        return ((pos >= start) && (pos < start + width)) ? pol : !pol;
    endfunction

    // Default 640x480 instance
    logic        rst_d, en_d, ce_d, hs_d, vs_d, blank_d, sync_d, ls_d, fs_d;
    logic [10:0] x_d, y_d;
    logic [15:0] fc_d;

    vga_timing_gen u_def (
        .Clk         (Clk),
        .Reset       (rst_d),
        .en          (en_d),
        .pixel_ce    (ce_d),
        .hs          (hs_d),
        .vs          (vs_d),
        .blank       (blank_d),
        .sync        (sync_d),
        .DrawX       (x_d),
        .DrawY       (y_d),
        .line_start  (ls_d),
        .frame_start (fs_d)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        ,
        .frame_count (fc_d)
`endif
    );

    // Reduced instance: H 16/2/4/3 (25), V 10/2/2/3 (17), CLK_DIV=3
    localparam int S_HT = 25;
    localparam int S_VT = 17;
    localparam int S_DIV = 3;
    logic       rst_s, en_s, ce_s, hs_s, vs_s, blank_s, sync_s, ls_s, fs_s;
    logic [5:0] x_s, y_s;
    logic [15:0] fc_s;

    vga_timing_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
        .V_ACTIVE (10), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .CLK_DIV  (S_DIV), .HS_POL (1'b0), .VS_POL (1'b0), .CW (6)
    ) u_small (
        .Clk         (Clk),
        .Reset       (rst_s),
        .en          (en_s),
        .pixel_ce    (ce_s),
        .hs          (hs_s),
        .vs          (vs_s),
        .blank       (blank_s),
        .sync        (sync_s),
        .DrawX       (x_s),
        .DrawY       (y_s),
        .line_start  (ls_s),
        .frame_start (fs_s)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        ,
        .frame_count (fc_s)
`endif
    );

    // Tiny instance: H 4/1/2/1 (8), V 1/1/1/1 (4), CLK_DIV=1, positive syncs
    logic       rst_t, en_t, ce_t, hs_t, vs_t, blank_t, sync_t, ls_t, fs_t;
    logic [3:0] x_t, y_t;
    logic [15:0] fc_t;

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (1), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .CLK_DIV  (1), .HS_POL (1'b1), .VS_POL (1'b1), .CW (4)
    ) u_tiny (
        .Clk         (Clk),
        .Reset       (rst_t),
        .en          (en_t),
        .pixel_ce    (ce_t),
        .hs          (hs_t),
        .vs          (vs_t),
        .blank       (blank_t),
        .sync        (sync_t),
        .DrawX       (x_t),
        .DrawY       (y_t),
        .line_start  (ls_t),
        .frame_start (fs_t)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        ,
        .frame_count (fc_t)
`endif
    );

    initial begin
        int  dc, dp, drop, lines, ce_line, vis_line, hsl_line;
        int  sc, sp, fsn, ex, ey;
        bit  chk640, post_rst, rst_done;
        logic exp_ce;

        fc_d = '0; fc_s = '0; fc_t = '0;
        rst_d = 1'b1; rst_s = 1'b1; rst_t = 1'b1;
        en_d = 1'b1; en_s = 1'b1; en_t = 1'b1;
        repeat (2) @(negedge Clk);
        #1;
        chk("rst_x", x_d, 0);
        chk("rst_y", y_d, 0);
        chk("rst_hs", hs_d, 1);
        chk("rst_vs", vs_d, 1);
        chk("rst_blank", blank_d, 1);
        chk("rst_ce", ce_d, 0);
        chk("rst_sync", sync_d, 0);
        chk("rst_ls", ls_d, 0);
        chk("rst_tiny_ce", ce_t, 0);
        chk("rst_tiny_hs", hs_t, 0);
        chk("rst_tiny_vs", vs_t, 0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        chk("rst_fc", fc_d, 0);
`endif

        // Default mode: two lines, with en dropped for 5 Clk at DrawX=639
        @(negedge Clk);
        rst_d = 1'b0;
        dc = 0; dp = 0; drop = 0; lines = 0; ce_line = 0; vis_line = 0; hsl_line = 0;
        chk640 = 1'b0;
        for (int k = 0; k < 3400; k++) begin
            en_d = !(dp == 639 && drop < 5);
            if (!en_d) drop++;
            #1;
            exp_ce = en_d && (dc % 2 == 1);
            ex = dp % 800;
            ey = (dp / 800) % 525;
            chk("def_x", x_d, ex);
            chk("def_y", y_d, ey);
            chk("def_ce", ce_d, exp_ce);
            chk("def_hs", hs_d, sync_exp(ex, 656, 96, 1'b0));
            chk("def_vs", vs_d, sync_exp(ey, 490, 2, 1'b0));
            chk("def_blank", blank_d, (ex < 640) && (ey < 480));
            chk("def_ls", ls_d, exp_ce && ex == 0);
            chk("def_fs", fs_d, exp_ce && ex == 0 && ey == 0);
            if (!en_d) begin
                chk("hold_x639", x_d, 639);
                chk("hold_strobes", {ce_d, ls_d, fs_d}, 0);
            end
            if (chk640) begin
                chk("resume_x640", x_d, 640);
                chk640 = 1'b0;
            end
            if (ls_d) begin
                if (lines > 0) begin
                    chk("ce_per_line", ce_line, 800);
                    chk("vis_per_line", vis_line, 640);
                    chk("hs_low_per_line", hsl_line, 96);
                end
                lines++;
                ce_line = 0; vis_line = 0; hsl_line = 0;
            end
            if (ce_d) begin
                ce_line++;
                if (blank_d) vis_line++;
                if (!hs_d) hsl_line++;
            end
            if (drop == 5 && exp_ce && ex == 639) chk640 = 1'b1;
            if (en_d) dc++;
            if (exp_ce) dp++;
            @(negedge Clk);
        end
        chk("def_lines", lines, 3);
        rst_d = 1'b1;

        // Reduced mode: random en, reset mid-frame, frame counting
        rst_s = 1'b0;
        sc = 0; sp = 0; fsn = 0; post_rst = 1'b0; rst_done = 1'b0;
        for (int k = 0; k < 8000; k++) begin
            if (!rst_done && sp == S_HT * S_VT + 8 * S_HT + 20) begin
                rst_done = 1'b1;
                rst_s = 1'b1;
                en_s = 1'b1;
                #1;
                chk("mid_rst_x", x_s, 0);
                chk("mid_rst_y", y_s, 0);
                chk("mid_rst_hs", hs_s, 1);
                chk("mid_rst_vs", vs_s, 1);
                chk("mid_rst_blank", blank_s, 1);
                chk("mid_rst_ce", ce_s, 0);
                repeat (3) begin
                    @(negedge Clk);
                    #1;
                    chk("in_rst_ce", ce_s, 0);
                    chk("in_rst_blank", blank_s, 1);
                end
                @(negedge Clk);
                rst_s = 1'b0;
                sc = 0; sp = 0; fsn = 0; post_rst = 1'b1;
            end
            en_s = ($urandom_range(0, 3) != 0);
            #1;
            exp_ce = en_s && (sc % S_DIV == S_DIV - 1);
            ex = sp % S_HT;
            ey = (sp / S_HT) % S_VT;
            chk("sm_x", x_s, ex);
            chk("sm_y", y_s, ey);
            chk("sm_ce", ce_s, exp_ce);
            chk("sm_hs", hs_s, sync_exp(ex, 18, 4, 1'b0));
            chk("sm_vs", vs_s, sync_exp(ey, 12, 2, 1'b0));
            chk("sm_blank", blank_s, (ex < 16) && (ey < 10));
            chk("sm_ls", ls_s, exp_ce && ex == 0);
            chk("sm_fs", fs_s, exp_ce && ex == 0 && ey == 0);
            chk("sm_sync", sync_s, 0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
            chk("sm_fc", fc_s, (fsn == 0) ? 0 : fsn - 1);
`endif
            if (post_rst && exp_ce) begin
                chk("first_ce_fs", fs_s, 1);
                post_rst = 1'b0;
            end
            if (en_s) sc++;
            if (exp_ce) begin
                if (ex == 0 && ey == 0) fsn++;
                sp++;
            end
            @(negedge Clk);
        end
        chk("sm_reset_hit", rst_done, 1);
        chk("sm_frames_after_rst", fsn >= 3, 1);
        rst_s = 1'b1;

        // CLK_DIV=1 with inverted syncs
        rst_t = 1'b0;
        en_t = 1'b1;
        for (int k = 0; k < 100; k++) begin
            #1;
            ex = k % 8;
            ey = (k / 8) % 4;
            chk("tiny_ce", ce_t, 1);
            chk("tiny_x", x_t, ex);
            chk("tiny_y", y_t, ey);
            chk("tiny_hs", hs_t, sync_exp(ex, 5, 2, 1'b1));
            chk("tiny_vs", vs_t, sync_exp(ey, 2, 1, 1'b1));
            chk("tiny_blank", blank_t, (ex < 4) && (ey < 1));
            chk("tiny_fs", fs_t, (k % 32) == 0);
            @(negedge Clk);
        end
        en_t = 1'b0;
        #1;
        chk("tiny_en_low_ce", ce_t, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
